// File: rtl/prog_loader_if.sv
// Byte stream feeding the program loader. A byte moves on a rising clk edge when
// byte_valid and byte_ready are both high; the source holds byte_in/byte_valid until then.
interface prog_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs a little-endian byte stream (3 bytes per word) into program RAM
// and releases the processor via run_en. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int CODE_W = 23,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    prog_loader_if.slave      stream,
    input  logic [ADDR_W-1:0] address,
    output logic [CODE_W-1:0] code,
    output logic              run_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_WR   = 3'd4,
        S_CK   = 3'd5,
        S_FIN  = 3'd6
    } state_t;

    localparam int              B2_W    = CODE_W - 16;
    // Bits of the third byte that do not fit in the code word.
    localparam logic [7:0]      B2_MASK = 8'hFF << B2_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            state_q;
    state_t            state_n;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        b0_q;
    logic [7:0]        b1_q;
    logic [B2_W-1:0]   b2_q;
    logic              ready;
    logic              accept;
    logic              start_ok;
    logic              last_word;
    logic              b2_overflow;
    logic [CODE_W-1:0] mem [DEPTH];
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign stream.byte_ready = ready;
    assign accept      = stream.byte_valid & ready;
    assign start_ok    = (load_len != '0) && (load_len <= DEPTH_L);
    assign last_word   = ({1'b0, ptr_q} == (len_q - LEN_ONE));
    assign b2_overflow = |(stream.byte_in & B2_MASK);
    assign state_dbg   = state_q;
    assign code        = run_en ? mem[address] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start && start_ok) state_n = S_B0;
            end
            S_B0: begin
                ready = 1'b1;
                if (accept) state_n = S_B1;
            end
            S_B1: begin
                ready = 1'b1;
                if (accept) state_n = S_B2;
            end
            S_B2: begin
                ready = 1'b1;
                if (accept) state_n = S_WR;
            end
            S_WR: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_n = S_CK;
`else
                    state_n = S_FIN;
`endif
                end else begin
                    state_n = S_B0;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CK: begin
                ready = 1'b1;
                if (accept) state_n = S_FIN;
            end
`endif
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            ptr_q  <= '0;
            b0_q   <= '0;
            b1_q   <= '0;
            b2_q   <= '0;
            err    <= 1'b0;
            run_en <= 1'b0;
            busy   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start) begin
                        run_en <= 1'b0;
                        if (!start_ok) begin
                            err <= 1'b1;
                        end else begin
                            len_q <= load_len;
                            err   <= 1'b0;
                            ptr_q <= '0;
                            busy  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            csum_q <= '0;
`endif
                        end
                    end
                end
                S_B0: begin
                    if (accept) b0_q <= stream.byte_in;
                end
                S_B1: begin
                    if (accept) b1_q <= stream.byte_in;
                end
                S_B2: begin
                    if (accept) begin
                        b2_q <= stream.byte_in[B2_W-1:0];
                        if (b2_overflow) err <= 1'b1;
                    end
                end
                S_WR: begin
                    if (!last_word) ptr_q <= ptr_q + PTR_ONE;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CK: begin
                    if (accept && (stream.byte_in != csum_q)) err <= 1'b1;
                end
`endif
                S_FIN: begin
                    busy   <= 1'b0;
                    run_en <= ~err;
                end
                default: ;
            endcase
`ifdef LOADER_CHECKSUM_EN
            // Every data byte (including the raw third byte) enters the checksum.
            if (accept && (state_q == S_B0 || state_q == S_B1 || state_q == S_B2))
                csum_q <= csum_q ^ stream.byte_in;
`endif
        end
    end

    // Program RAM is intentionally not reset; run_en gates what the processor sees.
    always_ff @(posedge clk) begin
        if (state_q == S_WR) mem[ptr_q] <= {b2_q, b1_q, b0_q};
    end

endmodule
